// File: rtl/clock_mode_ctrl.sv
// rtl/clock_mode_ctrl.sv - key-driven mode FSM, alarm registers, ring and blink control for the digital clock
module clock_mode_ctrl #(
  parameter int TIMEOUT_MS = 10000,
  parameter int RING_MS    = 60000,
  parameter int BLINK_MS   = 500
) (
  input  logic       Clk_50MHz,
  input  logic       Reset_N,
  input  logic       tick_ms,
  input  logic [3:0] key_pulse,
  input  logic [5:0] count_S,
  input  logic [5:0] count_M,
  input  logic [4:0] count_H,
  output logic       Add_S,
  output logic       Add_M,
  output logic       Add_H,
  output logic       Subtract_S,
  output logic       Subtract_M,
  output logic       Subtract_H,
  output logic [4:0] alarm_H,
  output logic [5:0] alarm_M,
  output logic       alarm_en,
  output logic       buzzer_on,
  output logic [7:0] blink_mask,
  output logic       disp_sel,
  output logic [2:0] mode
);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_SET_H = 3'd1,
    ST_SET_M = 3'd2,
    ST_SET_S = 3'd3,
    ST_AL_H  = 3'd4,
    ST_AL_M  = 3'd5,
    ST_RING  = 3'd6
  } state_t;

  localparam int IDLE_W  = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;
  localparam int RING_W  = (RING_MS    > 1) ? $clog2(RING_MS)    : 1;
  localparam int BLINK_W = (BLINK_MS   > 1) ? $clog2(BLINK_MS)   : 1;

  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_MS - 1);
  localparam logic [RING_W-1:0]  RING_LAST  = RING_W'(RING_MS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

  // State and counters
  state_t               r_state;
  state_t               w_state_next;
  logic [IDLE_W-1:0]    r_idle_cnt;
  logic [RING_W-1:0]    r_ring_cnt;
  logic [BLINK_W-1:0]   r_blink_cnt;
  logic                 r_blink_phase;   // 1 = blank
  logic                 r_match;
  logic                 r_match_d;

  // Registered outputs
  logic       r_add_s, r_add_m, r_add_h;
  logic       r_sub_s, r_sub_m, r_sub_h;
  logic [4:0] r_alarm_h;
  logic [5:0] r_alarm_m;
  logic       r_alarm_en;
  logic       r_buzzer;
  logic [7:0] r_blink_mask;
  logic       r_disp_sel;

  // Combinational next values
  logic       w_add_s, w_add_m, w_add_h;
  logic       w_sub_s, w_sub_m, w_sub_h;
  logic [4:0] w_alarm_h_next;
  logic [5:0] w_alarm_m_next;
  logic       w_alarm_en_next;
  logic       w_updown;
  logic [BLINK_W-1:0] w_blink_cnt_next;
  logic       w_blink_phase_next;
  logic [7:0] w_mask_next;

  // Key decode: only the highest-priority key (MODE > OK > UP > DOWN) is acted on
  logic w_key_mode, w_key_ok, w_key_up, w_key_dn, w_any_key;
  assign w_key_mode = key_pulse[0];
  assign w_key_ok   = key_pulse[3] & ~key_pulse[0];
  assign w_key_up   = key_pulse[1] & ~key_pulse[0] & ~key_pulse[3];
  assign w_key_dn   = key_pulse[2] & ~key_pulse[0] & ~key_pulse[3] & ~key_pulse[1];
  assign w_any_key  = |key_pulse;

  logic w_in_set, w_state_chg, w_timeout, w_ring_done, w_match, w_match_rise;
  assign w_in_set     = (r_state >= ST_SET_H) && (r_state <= ST_AL_M);
  assign w_state_chg  = (w_state_next != r_state);
  assign w_timeout    = w_in_set && tick_ms && (r_idle_cnt == IDLE_LAST);
  assign w_ring_done  = (r_state == ST_RING) && tick_ms && (r_ring_cnt == RING_LAST);
  assign w_match      = r_alarm_en && (count_H == r_alarm_h) && (count_M == r_alarm_m) &&
                        (count_S == 6'd0);
  assign w_match_rise = r_match && !r_match_d;

  // State register
  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) r_state <= ST_RUN;
    else          r_state <= w_state_next;
  end

  // Next-state, counter pulses and alarm register updates
  always_comb begin
    w_state_next    = r_state;
    w_add_s         = 1'b0;
    w_add_m         = 1'b0;
    w_add_h         = 1'b0;
    w_sub_s         = 1'b0;
    w_sub_m         = 1'b0;
    w_sub_h         = 1'b0;
    w_alarm_h_next  = r_alarm_h;
    w_alarm_m_next  = r_alarm_m;
    w_alarm_en_next = r_alarm_en;
    w_updown        = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_key_mode)        w_state_next = ST_SET_H;
        else if (w_key_ok)     w_alarm_en_next = ~r_alarm_en;
        else if (w_match_rise) w_state_next = ST_RING;
      end
      ST_SET_H, ST_SET_M, ST_SET_S: begin
        if (w_key_mode) begin
          case (r_state)
            ST_SET_H: w_state_next = ST_SET_M;
            ST_SET_M: w_state_next = ST_SET_S;
            default:  w_state_next = ST_AL_H;
          endcase
        end else if (w_key_ok) begin
          w_state_next = ST_RUN;
        end else if (w_key_up || w_key_dn) begin
          w_updown = 1'b1;
          w_add_h  = w_key_up && (r_state == ST_SET_H);
          w_add_m  = w_key_up && (r_state == ST_SET_M);
          w_add_s  = w_key_up && (r_state == ST_SET_S);
          w_sub_h  = w_key_dn && (r_state == ST_SET_H);
          w_sub_m  = w_key_dn && (r_state == ST_SET_M);
          w_sub_s  = w_key_dn && (r_state == ST_SET_S);
        end else if (w_timeout) begin
          w_state_next = ST_RUN;
        end
      end
      ST_AL_H: begin
        if (w_key_mode)    w_state_next = ST_AL_M;
        else if (w_key_ok) w_state_next = ST_RUN;
        else if (w_key_up) begin
          w_updown       = 1'b1;
          w_alarm_h_next = (r_alarm_h == 5'd23) ? 5'd0 : r_alarm_h + 5'd1;
        end else if (w_key_dn) begin
          w_updown       = 1'b1;
          w_alarm_h_next = (r_alarm_h == 5'd0) ? 5'd23 : r_alarm_h - 5'd1;
        end else if (w_timeout) w_state_next = ST_RUN;
      end
      ST_AL_M: begin
        if (w_key_mode || w_key_ok) w_state_next = ST_RUN;
        else if (w_key_up) begin
          w_updown       = 1'b1;
          w_alarm_m_next = (r_alarm_m == 6'd59) ? 6'd0 : r_alarm_m + 6'd1;
        end else if (w_key_dn) begin
          w_updown       = 1'b1;
          w_alarm_m_next = (r_alarm_m == 6'd0) ? 6'd59 : r_alarm_m - 6'd1;
        end else if (w_timeout) w_state_next = ST_RUN;
      end
      ST_RING: begin
        // Any key only dismisses the ring; it has no other effect
        if (w_any_key || w_ring_done) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  // Blink phase: free-running only while setting, restarted on state change or UP/DOWN
  always_comb begin
    w_blink_cnt_next   = r_blink_cnt;
    w_blink_phase_next = r_blink_phase;
    w_mask_next        = 8'h00;
    if (!w_in_set || w_state_chg || w_updown) begin
      w_blink_cnt_next   = '0;
      w_blink_phase_next = 1'b0;
    end else if (tick_ms) begin
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_cnt_next   = '0;
        w_blink_phase_next = ~r_blink_phase;
      end else begin
        w_blink_cnt_next = r_blink_cnt + BLINK_W'(1);
      end
    end
    if (w_blink_phase_next) begin
      case (w_state_next)
        ST_SET_H, ST_AL_H: w_mask_next = 8'b1100_0000;
        ST_SET_M, ST_AL_M: w_mask_next = 8'b0001_1000;
        ST_SET_S:          w_mask_next = 8'b0000_0011;
        default:           w_mask_next = 8'h00;
      endcase
    end
  end

  // Idle timeout counter: counts ms while setting, cleared by any key or state change
  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N)                                  r_idle_cnt <= '0;
    else if (!w_in_set || w_state_chg || w_any_key) r_idle_cnt <= '0;
    else if (tick_ms)                              r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
  end

  // Ring duration counter: counts ms only while ringing
  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N)                                r_ring_cnt <= '0;
    else if (r_state != ST_RING || w_state_chg)  r_ring_cnt <= '0;
    else if (tick_ms)                            r_ring_cnt <= r_ring_cnt + RING_W'(1);
  end

  // Blink counter and phase registers
  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_blink_cnt   <= w_blink_cnt_next;
      r_blink_phase <= w_blink_phase_next;
    end
  end

  // Alarm match pipeline; only a fresh rise can start a ring
  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      r_match   <= 1'b0;
      r_match_d <= 1'b0;
    end else begin
      r_match   <= w_match;
      r_match_d <= r_match;
    end
  end

  // Output registers, loaded from next-state values so they track the state without lag
  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      r_add_s      <= 1'b0;
      r_add_m      <= 1'b0;
      r_add_h      <= 1'b0;
      r_sub_s      <= 1'b0;
      r_sub_m      <= 1'b0;
      r_sub_h      <= 1'b0;
      r_alarm_h    <= 5'd7;
      r_alarm_m    <= 6'd0;
      r_alarm_en   <= 1'b0;
      r_buzzer     <= 1'b0;
      r_blink_mask <= 8'h00;
      r_disp_sel   <= 1'b0;
    end else begin
      r_add_s      <= w_add_s;
      r_add_m      <= w_add_m;
      r_add_h      <= w_add_h;
      r_sub_s      <= w_sub_s;
      r_sub_m      <= w_sub_m;
      r_sub_h      <= w_sub_h;
      r_alarm_h    <= w_alarm_h_next;
      r_alarm_m    <= w_alarm_m_next;
      r_alarm_en   <= w_alarm_en_next;
      r_buzzer     <= (w_state_next == ST_RING);
      r_blink_mask <= w_mask_next;
      r_disp_sel   <= (w_state_next == ST_AL_H) || (w_state_next == ST_AL_M);
    end
  end

  assign Add_S      = r_add_s;
  assign Add_M      = r_add_m;
  assign Add_H      = r_add_h;
  assign Subtract_S = r_sub_s;
  assign Subtract_M = r_sub_m;
  assign Subtract_H = r_sub_h;
  assign alarm_H    = r_alarm_h;
  assign alarm_M    = r_alarm_m;
  assign alarm_en   = r_alarm_en;
  assign buzzer_on  = r_buzzer;
  assign blink_mask = r_blink_mask;
  assign disp_sel   = r_disp_sel;
  assign mode       = r_state;

endmodule
